// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and access owner.
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access-window counter: loaded with MEM_LAT-1 on a grant, counts down once per busy cycle.
module arb_lat_counter #(
  parameter int unsigned MEM_LAT = 2,
  localparam int unsigned LW = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  logic [LW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= LW'(MEM_LAT - 1);
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data side
// preferred with a starvation counter that forces a fetch grant after FAIR_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int unsigned SW = $clog2(FAIR_MAX + 1);

  arb_state_t    r_state;
  logic [SW-1:0] r_starve;
  owner_t        w_own;
  logic          w_idle, w_if_req_m, w_d_req_m, w_grant_d, w_grant_i, w_lat_zero;

  // A requester still holding req during its own ack cycle must not be granted again.
  assign w_if_req_m = if_req & ~if_ack;
  assign w_d_req_m  = d_req & ~d_ack;
  assign w_idle     = (r_state == ARB_IDLE);
  assign w_grant_d  = w_idle & w_d_req_m & (~w_if_req_m | (r_starve < SW'(FAIR_MAX)));
  assign w_grant_i  = w_idle & ~w_grant_d & w_if_req_m;
  assign w_own      = w_grant_d ? OWN_D : OWN_I;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_grant_d | w_grant_i),
    .i_dec  (~w_idle),
    .o_zero (w_lat_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_starve  <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d | w_grant_i) begin
            r_state  <= (w_own == OWN_D) ? ARB_BUSY_D : ARB_BUSY_I;
            mem_en   <= 1'b1;
            mem_we   <= w_grant_d & d_we;
            mem_addr <= (w_own == OWN_D) ? d_addr : if_addr;
            if (w_grant_d)
              mem_wdata <= d_wdata;
          end
          if (!if_req || w_grant_i)
            r_starve <= '0;
          else if (w_grant_d && (r_starve != SW'(FAIR_MAX)))
            r_starve <= r_starve + 1'b1;
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (w_lat_zero) begin
            if (r_state == ARB_BUSY_I) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timestamp reference model, directed scenarios, random traffic.
module tb_mem_port_arbiter;
  localparam int unsigned MEM_LAT  = 2;
  localparam int unsigned FAIR_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .FAIR_MAX(FAIR_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an access granted at the edge ending cycle c owns the memory
  // for cycles c+1..c+MEM_LAT and acks in cycle c+MEM_LAT+1.
  int          cyc = 0;
  bit          m_busy = 0, m_own_d = 0, m_we = 0;
  int          m_end = 0, m_starve = 0;
  logic        e_if_ack = 0, e_d_ack = 0, e_en = 0, e_we = 0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_addr = '0, e_wdata = '0;

  always @(posedge clk) begin
    bit n_if_ack, n_d_ack, im, dm, gd, gi;
    n_if_ack = 0;
    n_d_ack  = 0;
    if (reset) begin
      m_busy = 0; m_starve = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else if (m_busy) begin
      if (cyc == m_end) begin
        if (!m_own_d) begin
          e_if_rdata = mem_rdata; n_if_ack = 1;
        end else begin
          if (!m_we) e_d_rdata = mem_rdata;
          n_d_ack = 1;
        end
        m_busy = 0; e_en = 0; e_we = 0;
      end
    end else begin
      im = if_req && !e_if_ack;
      dm = d_req && !e_d_ack;
      gd = dm && (!im || m_starve < FAIR_MAX);
      gi = !gd && im;
      if (gd || gi) begin
        m_busy  = 1;
        m_end   = cyc + MEM_LAT;
        m_own_d = gd;
        m_we    = gd && d_we;
        e_en    = 1;
        e_we    = m_we;
        e_addr  = gd ? d_addr : if_addr;
        if (gd) e_wdata = d_wdata;
      end
      if (gi || !if_req) m_starve = 0;
      else if (gd) m_starve = (m_starve + 1 > FAIR_MAX) ? FAIR_MAX : m_starve + 1;
    end
    e_if_ack = n_if_ack;
    e_d_ack  = n_d_ack;
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_ack", {31'b0, if_ack}, {31'b0, e_if_ack});
      chk("d_ack", {31'b0, d_ack}, {31'b0, e_d_ack});
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      if (e_en) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~e_if_ack});
      chk("stall_mem", {31'b0, stall_mem}, {31'b0, d_req & ~e_d_ack});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    if_req = 0; d_req = 0; d_we = 0;
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    nxt();
    chk_en = 1;
    @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    nxt();
    reset = 0;
    idle(2);

    // fetch only
    if_req = 1; if_addr = 32'h10; mem_rdata = 32'h20020005;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        chk("fetch_en", {31'b0, mem_en}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h10);
      end
      if (k == 3) begin
        chk("fetch_ack", {31'b0, if_ack}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h20020005);
        chk("model_fetch_rdata", e_if_rdata, 32'h20020005);
      end
      nxt();
    end
    idle(3);

    // simultaneous fetch and load: data first
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h100;
    mem_rdata = 32'hA5A5A5A5;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) chk("sim_stall_if", {31'b0, stall_if}, 32'd1);
      if (k == 1) chk("sim_d_addr", mem_addr, 32'h100);
      if (k == 3) begin
        chk("sim_d_ack", {31'b0, d_ack}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'hA5A5A5A5);
      end
      if (k == 4) chk("sim_i_addr", mem_addr, 32'h10);
      if (k == 6) begin
        chk("sim_if_ack", {31'b0, if_ack}, 32'd1);
        chk("sim_stall_if_end", {31'b0, stall_if}, 32'd0);
      end
      nxt();
      if (k == 3) d_req = 0;
    end
    idle(3);

    // store leaves d_rdata untouched
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        chk("st_we", {31'b0, mem_we}, 32'd1);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_addr", mem_addr, 32'h200);
      end
      if (k == 3) begin
        chk("st_ack", {31'b0, d_ack}, 32'd1);
        chk("st_rdata_hold", d_rdata, 32'hA5A5A5A5);
      end
      nxt();
    end
    idle(3);

    // reset in busy cycle 2 aborts, then a re-request completes
    if_req = 1; if_addr = 32'h44; mem_rdata = 32'h0BADF00D;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) chk("rst_busy_en", {31'b0, mem_en}, 32'd1);
      if (k == 3) begin
        chk("rst_abort_en", {31'b0, mem_en}, 32'd0);
        chk("rst_abort_ack", {31'b0, if_ack}, 32'd0);
        chk("rst_abort_rdata", if_rdata, 32'd0);
      end
      if (k == 6) begin
        chk("rst_redo_ack", {31'b0, if_ack}, 32'd1);
        chk("rst_redo_rdata", if_rdata, 32'h0BADF00D);
      end
      nxt();
      if (k == 1) reset = 1;
      if (k == 2) reset = 0;
    end
    idle(3);

    // load request dropped mid-access still completes, no regrant
    d_req = 1; d_we = 0; d_addr = 32'h300; mem_rdata = 32'h600D600D;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("drop_ack", {31'b0, d_ack}, 32'd1);
        chk("drop_rdata", d_rdata, 32'h600D600D);
      end
      if (k >= 4) chk("drop_no_regrant", {31'b0, mem_en}, 32'd0);
      nxt();
      if (k == 0) d_req = 0;
    end
    idle(3);

    // both requesters held continuously
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int k = 0; k < 20; k++) begin
      mem_rdata = $urandom();
      nxt();
    end
    idle(6);

    // random traffic honouring hold-until-ack, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset = ($urandom_range(0, 199) == 0);
      mem_rdata = $urandom();
      if (if_req) begin
        if (if_ack) begin
          if ($urandom_range(0, 1) == 1) if_req = 0;
          else if_addr = $urandom();
        end else if ($urandom_range(0, 29) == 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom();
      end
      if (d_req) begin
        if (d_ack) begin
          if ($urandom_range(0, 1) == 1) d_req = 0;
          else begin
            d_we = $urandom_range(0, 1) == 1; d_addr = $urandom(); d_wdata = $urandom();
          end
        end else if ($urandom_range(0, 29) == 0) d_req = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom(); d_wdata = $urandom();
      end
    end
    reset = 0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
